// File: rtl/vga_scandoubler_ng.sv
// Line-doubling VGA scan converter: captures each 15 kHz input line into one half of a
// ping-pong buffer and replays the other half twice at the full clk rate.
module vga_scandoubler_ng #(
    parameter int CDEPTH   = 3,
    parameter int HMAX     = 1024,
    parameter int ADDRW    = 10,
    parameter int HS_START = 16,
    parameter int HS_END   = 72
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk14en,
    input  logic              enable_scandoubling,
    input  logic [1:0]        scan_level,
    input  logic [CDEPTH-1:0] ri,
    input  logic [CDEPTH-1:0] gi,
    input  logic [CDEPTH-1:0] bi,
    input  logic              hsync_ext_n,
    input  logic              vsync_ext_n,
    input  logic              csync_ext_n,
    output logic [CDEPTH-1:0] ro,
    output logic [CDEPTH-1:0] go,
    output logic [CDEPTH-1:0] bo,
    output logic              hsync,
    output logic              vsync,
    output logic              line_overflow
);

    localparam int PW = 3 * CDEPTH;
    localparam logic [ADDRW:0] HMAX_C     = (ADDRW+1)'(HMAX);
    localparam logic [ADDRW:0] HS_START_C = (ADDRW+1)'(HS_START);
    localparam logic [ADDRW:0] HS_END_C   = (ADDRW+1)'(HS_END);
    localparam logic [ADDRW:0] CNT_ONE    = {{ADDRW{1'b0}}, 1'b1};

    // Both line halves live in one array; the top address bit selects the half.
    logic [PW-1:0] line_mem [0:2*HMAX-1];
    logic [PW-1:0] rd_data_q;

    // Write side
    logic             hs_prev_q, hs_prev_d;
    logic [ADDRW:0]   wcnt_q, wcnt_d;
    logic             wsel_q, wsel_d;
    logic [ADDRW:0]   linelen_q, linelen_d;
    logic             ovf_q, ovf_d;
    logic             vs_pend_q, vs_pend_d;

    // Read side
    logic [ADDRW:0]   rcnt_q, rcnt_d;
    logic             replay_q, replay_d;
    logic             active_q, active_d;
    logic             vs_cur_q, vs_cur_d;

    // RAM-read stage companions
    logic             valid1_q, valid1_d;
    logic             replay1_q, replay1_d;
    logic             hs1_q, hs1_d;
    logic             vs1_q, vs1_d;

    // Output registers
    logic [CDEPTH-1:0] ro_q, ro_d;
    logic [CDEPTH-1:0] go_q, go_d;
    logic [CDEPTH-1:0] bo_q, bo_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;

    logic             hs_edge;
    logic             wr_en;
    logic             line_start;
    logic [ADDRW:0]   wr_addr;
    logic [ADDRW:0]   rd_addr;
    logic [CDEPTH-1:0] pix_r, pix_g, pix_b;

    function automatic logic [CDEPTH-1:0] dim(input logic [CDEPTH-1:0] v,
                                              input logic [1:0] lvl);
        logic [CDEPTH-1:0] res;
        case (lvl)
            2'd0:    res = v;
            2'd1:    res = v - (v >> 2);
            2'd2:    res = v >> 1;
            default: res = v >> 2;
        endcase
        return res;
    endfunction

    assign hs_edge = clk14en & hs_prev_q & ~hsync_ext_n;
    // The enable that carries the hsync edge closes the line and stores nothing.
    assign wr_en   = clk14en & ~hs_edge & (wcnt_q != HMAX_C);
    assign wr_addr = {wsel_q, wcnt_q[ADDRW-1:0]};
    assign rd_addr = {~wsel_q, rcnt_q[ADDRW-1:0]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_addr] <= {ri, gi, bi};
        end
        rd_data_q <= line_mem[rd_addr];
    end

    always_comb begin
        hs_prev_d = hs_prev_q;
        wcnt_d    = wcnt_q;
        wsel_d    = wsel_q;
        linelen_d = linelen_q;
        ovf_d     = ovf_q;
        vs_pend_d = vs_pend_q;
        if (clk14en) begin
            hs_prev_d = hsync_ext_n;
            if (wcnt_q == HMAX_C) begin
                ovf_d = 1'b1;
            end
            if (hs_edge) begin
                linelen_d = wcnt_q;
                wcnt_d    = '0;
                wsel_d    = ~wsel_q;
                vs_pend_d = vsync_ext_n;
            end else if (wcnt_q != HMAX_C) begin
                wcnt_d = wcnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        rcnt_d     = rcnt_q;
        replay_d   = replay_q;
        active_d   = active_q;
        line_start = active_q && (rcnt_q == '0) && !replay_q;
        if (hs_edge) begin
            rcnt_d   = '0;
            replay_d = 1'b0;
            active_d = (wcnt_q != '0);
        end else if (active_q) begin
            if (rcnt_q == linelen_q - CNT_ONE) begin
                rcnt_d = '0;
                if (replay_q) begin
                    active_d = 1'b0;
                end else begin
                    replay_d = 1'b1;
                end
            end else begin
                rcnt_d = rcnt_q + CNT_ONE;
            end
        end
        // Vertical sync only changes on an output line boundary.
        vs_cur_d  = line_start ? vs_pend_q : vs_cur_q;
        valid1_d  = active_q;
        replay1_d = replay_q;
        hs1_d     = active_q && (rcnt_q >= HS_START_C) && (rcnt_q < HS_END_C);
        vs1_d     = vs_cur_d;
    end

    assign pix_r = rd_data_q[PW-1 -: CDEPTH];
    assign pix_g = rd_data_q[2*CDEPTH-1 -: CDEPTH];
    assign pix_b = rd_data_q[CDEPTH-1:0];

    always_comb begin
        ro_d    = ro_q;
        go_d    = go_q;
        bo_d    = bo_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (!enable_scandoubling) begin
            if (clk14en) begin
                ro_d    = ri;
                go_d    = gi;
                bo_d    = bi;
                hsync_d = csync_ext_n;
            end
            vsync_d = 1'b1;
        end else begin
            if (valid1_q) begin
                ro_d = replay1_q ? dim(pix_r, scan_level) : pix_r;
                go_d = replay1_q ? dim(pix_g, scan_level) : pix_g;
                bo_d = replay1_q ? dim(pix_b, scan_level) : pix_b;
            end else begin
                ro_d = '0;
                go_d = '0;
                bo_d = '0;
            end
            hsync_d = ~hs1_q;
            vsync_d = vs1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_prev_q <= 1'b1;
            wcnt_q    <= '0;
            wsel_q    <= 1'b0;
            linelen_q <= '0;
            ovf_q     <= 1'b0;
            vs_pend_q <= 1'b1;
            rcnt_q    <= '0;
            replay_q  <= 1'b0;
            active_q  <= 1'b0;
            vs_cur_q  <= 1'b1;
            valid1_q  <= 1'b0;
            replay1_q <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b1;
            ro_q      <= '0;
            go_q      <= '0;
            bo_q      <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            hs_prev_q <= hs_prev_d;
            wcnt_q    <= wcnt_d;
            wsel_q    <= wsel_d;
            linelen_q <= linelen_d;
            ovf_q     <= ovf_d;
            vs_pend_q <= vs_pend_d;
            rcnt_q    <= rcnt_d;
            replay_q  <= replay_d;
            active_q  <= active_d;
            vs_cur_q  <= vs_cur_d;
            valid1_q  <= valid1_d;
            replay1_q <= replay1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            ro_q      <= ro_d;
            go_q      <= go_d;
            bo_q      <= bo_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign ro            = ro_q;
    assign go            = go_q;
    assign bo            = bo_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign line_overflow = ovf_q;

endmodule

// File: tb/tb_vga_scandoubler_ng.sv
// Scoreboard bench: a write-side model pushes time-stamped expected output pixels at
// every input hsync edge; a negedge monitor pops and compares them (black otherwise).
module tb_vga_scandoubler_ng;

    localparam int HMAX = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk14en = 1'b0;
    logic       enable_scandoubling = 1'b1;
    logic [1:0] scan_level = 2'd0;
    logic [2:0] ri = '0, gi = '0, bi = '0;
    logic       hsync_ext_n = 1'b1, vsync_ext_n = 1'b1, csync_ext_n = 1'b1;
    logic [2:0] ro, go, bo;
    logic       hsync, vsync, line_overflow;

    vga_scandoubler_ng dut (
        .clk(clk), .rst(rst), .clk14en(clk14en),
        .enable_scandoubling(enable_scandoubling), .scan_level(scan_level),
        .ri(ri), .gi(gi), .bi(bi),
        .hsync_ext_n(hsync_ext_n), .vsync_ext_n(vsync_ext_n), .csync_ext_n(csync_ext_n),
        .ro(ro), .go(go), .bo(bo),
        .hsync(hsync), .vsync(vsync), .line_overflow(line_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         stamp;
        logic [2:0] r, g, b;
        logic       hs, vs;
    } exp_t;
    exp_t sbq[$];

    int   checks = 0;
    int   failures = 0;
    int   pop_count = 0;
    int   vs_low_seen = 0;
    logic mon_en = 1'b0;
    logic vs_hold = 1'b1;

    logic [8:0] mbuf [0:HMAX-1];
    int         m_wcnt = 0;
    logic       m_hs_prev = 1'b1;

    function automatic logic [2:0] exp_dim(input logic [2:0] v, input logic [1:0] lvl);
        int x;
        x = int'(v);
        case (lvl)
            2'd0:    return v;
            2'd1:    return 3'(x - x / 4);
            2'd2:    return 3'(x / 2);
            default: return 3'(x / 4);
        endcase
    endfunction

    // One input pixel enable (one clk high, one clk low) plus the write-side model.
    task automatic en_pixel(input logic hs_n, input logic vs_n, input logic [2:0] r,
                            input logic [2:0] g, input logic [2:0] b, input logic cs_n,
                            input logic [1:0] lvl);
        int   start;
        int   idx;
        exp_t e;
        @(negedge clk);
        hsync_ext_n = hs_n; vsync_ext_n = vs_n; csync_ext_n = cs_n;
        ri = r; gi = g; bi = b; scan_level = lvl; clk14en = 1'b1;
        if (m_hs_prev && !hs_n) begin
            start = cyc + 3;
            while (sbq.size() > 0 && sbq[$].stamp >= start) void'(sbq.pop_back());
            for (int k = 0; k < 2 * m_wcnt; k++) begin
                idx     = k % m_wcnt;
                e.stamp = start + k;
                e.r     = mbuf[idx][8:6];
                e.g     = mbuf[idx][5:3];
                e.b     = mbuf[idx][2:0];
                if (k >= m_wcnt) begin
                    e.r = exp_dim(e.r, lvl);
                    e.g = exp_dim(e.g, lvl);
                    e.b = exp_dim(e.b, lvl);
                end
                e.hs = !(idx >= 16 && idx < 72);
                e.vs = vs_n;
                sbq.push_back(e);
            end
            $display("line edge at cyc %0d: len=%0d vs=%0b lvl=%0d", cyc, m_wcnt, vs_n, lvl);
            m_wcnt = 0;
        end else if (m_wcnt < HMAX) begin
            mbuf[m_wcnt] = {r, g, b};
            m_wcnt++;
        end
        m_hs_prev = hs_n;
        @(negedge clk);
        clk14en = 1'b0;
    endtask

    task automatic line_edge(input logic vs_n, input logic [1:0] lvl);
        en_pixel(1'b0, vs_n, 3'd0, 3'd0, 3'd0, 1'b1, lvl);
    endtask

    task automatic pix(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
        en_pixel(1'b1, vsync_ext_n, r, g, b, 1'b1, scan_level);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) pix(3'(i), 3'(i + 3), 3'(i + 5));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (sbq.size() > 0 && sbq[0].stamp < cyc) begin
                checks++; failures++;
                $display("FAIL missed_pixel stamp=%0d seen at cyc=%0d", sbq[0].stamp, cyc);
                void'(sbq.pop_front());
            end
            if (sbq.size() > 0 && sbq[0].stamp == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                pop_count++;
                if (vsync === 1'b0) vs_low_seen++;
                if ({ro, go, bo, hsync, vsync} !== {e.r, e.g, e.b, e.hs, e.vs}) begin
                    failures++;
                    $display("FAIL pixel cyc=%0d got rgb=%0d/%0d/%0d hs=%b vs=%b need rgb=%0d/%0d/%0d hs=%b vs=%b",
                             cyc, ro, go, bo, hsync, vsync, e.r, e.g, e.b, e.hs, e.vs);
                end
                vs_hold = e.vs;
            end else begin
                checks++;
                if ({ro, go, bo, hsync, vsync} !== {9'd0, 1'b1, vs_hold}) begin
                    failures++;
                    $display("FAIL black cyc=%0d got rgb=%0d/%0d/%0d hs=%b vs=%b need 0/0/0 hs=1 vs=%b",
                             cyc, ro, go, bo, hsync, vsync, vs_hold);
                end
            end
        end
    end

    task automatic set_mon(input logic en);
        @(posedge clk);
        #2 mon_en = en;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({ro, go, bo} !== 9'd0) begin
            failures++; $display("FAIL reset_rgb got %0h need 0", {ro, go, bo});
        end
        checks++;
        if ({hsync, vsync, line_overflow} !== 3'b110) begin
            failures++; $display("FAIL reset_sync got %b need 110", {hsync, vsync, line_overflow});
        end
        rst = 1'b0;
        set_mon(1'b1);
        $display("test_reset done");
    endtask

    task automatic test_ramp;
        int p0;
        p0 = pop_count;
        line_edge(1'b1, 2'd0);
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 448; i++) pix(3'(i % 8), 3'((i + 1) % 8), 3'((i + 2) % 8));
            line_edge(1'b1, 2'd0);
        end
        drain(460);
        checks++;
        if (pop_count - p0 != 2 * 896) begin
            failures++; $display("FAIL ramp_count got %0d need %0d", pop_count - p0, 2 * 896);
        end
        $display("test_ramp done");
    endtask

    task automatic test_scanlines;
        line_edge(1'b1, 2'd0);
        for (int lvl = 1; lvl <= 3; lvl++) begin
            for (int i = 0; i < 100; i++) pix(3'd7, 3'd7, 3'd7);
            line_edge(1'b1, 2'(lvl));
        end
        drain(110);
        $display("test_scanlines done");
    endtask

    task automatic test_vsync;
        logic [5:0] pattern;
        int v0;
        pattern = 6'b110001;
        v0 = vs_low_seen;
        for (int l = 0; l < 6; l++) begin
            line_edge(pattern[l], 2'd0);
            if (l < 5) for (int i = 0; i < 100; i++) pix(3'(i), 3'(i + 1), 3'(i + 2));
        end
        drain(110);
        checks++;
        if (vs_low_seen - v0 != 600) begin
            failures++; $display("FAIL vsync_low_pixels got %0d need 600", vs_low_seen - v0);
        end
        $display("test_vsync done");
    endtask

    task automatic test_overflow;
        line_edge(1'b1, 2'd0);
        for (int i = 0; i < 1100; i++) begin
            pix(3'(i % 8), 3'((i / 8) % 8), 3'((i / 64) % 8));
            if (i == 1023) begin
                checks++;
                if (line_overflow !== 1'b0) begin
                    failures++; $display("FAIL ovf_early got %b need 0", line_overflow);
                end
            end
            if (i == 1024) begin
                checks++;
                if (line_overflow !== 1'b1) begin
                    failures++; $display("FAIL ovf_set got %b need 1", line_overflow);
                end
            end
        end
        line_edge(1'b1, 2'd0);
        for (int i = 0; i < 1030; i++) pix(3'((i + 3) % 8), 3'(i % 5), 3'(i % 3));
        line_edge(1'b1, 2'd0);
        drain(1030);
        checks++;
        if (line_overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_sticky got %b need 1", line_overflow);
        end
        $display("test_overflow done");
    endtask

    task automatic test_bypass;
        logic cs;
        set_mon(1'b0);
        @(negedge clk);
        enable_scandoubling = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cs = (i % 3 == 0);
            en_pixel(1'b1, 1'b0, 3'd5, 3'(i), 3'(7 - i), cs, 2'd0);
            checks++;
            if ({ro, go, bo, hsync, vsync} !== {3'd5, 3'(i), 3'(7 - i), cs, 1'b1}) begin
                failures++;
                $display("FAIL bypass i=%0d got rgb=%0d/%0d/%0d hs=%b vs=%b need 5/%0d/%0d hs=%b vs=1",
                         i, ro, go, bo, hsync, vsync, i, 7 - i, cs);
            end
        end
        @(negedge clk);
        checks++;
        if (hsync !== cs || ro !== 3'd5) begin
            failures++; $display("FAIL bypass_hold got hs=%b r=%0d need hs=%b r=5", hsync, ro, cs);
        end
        enable_scandoubling = 1'b1;
        repeat (2) @(negedge clk);
        set_mon(1'b1);
        $display("test_bypass done");
    endtask

    task automatic test_reset_mid_replay;
        line_edge(1'b1, 2'd1);
        for (int i = 0; i < 100; i++) pix(3'(i % 7 + 1), 3'(i % 5 + 1), 3'(i % 3 + 1));
        line_edge(1'b1, 2'd1);
        drain(65);
        set_mon(1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({ro, go, bo, hsync, vsync, line_overflow} !== {9'd0, 3'b110}) begin
            failures++;
            $display("FAIL rst_async got rgb=%0h hs=%b vs=%b ovf=%b need 0 1 1 0",
                     {ro, go, bo}, hsync, vsync, line_overflow);
        end
        sbq.delete();
        m_wcnt    = 0;
        m_hs_prev = 1'b1;
        vs_hold   = 1'b1;
        @(negedge clk);
        checks++;
        if ({ro, go, bo, hsync, vsync, line_overflow} !== {9'd0, 3'b110}) begin
            failures++;
            $display("FAIL rst_next_clk got rgb=%0h hs=%b vs=%b ovf=%b need 0 1 1 0",
                     {ro, go, bo}, hsync, vsync, line_overflow);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_mon(1'b1);
        line_edge(1'b1, 2'd0);
        for (int i = 0; i < 100; i++) pix(3'(i), 3'(i * 3), 3'(i * 5));
        line_edge(1'b1, 2'd2);
        drain(110);
        checks++;
        if (line_overflow !== 1'b0) begin
            failures++; $display("FAIL ovf_after_rst got %b need 0", line_overflow);
        end
        $display("test_reset_mid_replay done");
    endtask

    initial begin
        test_reset;
        test_ramp;
        test_scanlines;
        test_vsync;
        test_overflow;
        test_bypass;
        test_reset_mid_replay;
        set_mon(1'b0);
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL scoreboard_left got %0d entries need 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scandoubler_ng.md
Name: vga_scandoubler_ng

Overview:
- Parametrised successor to the fixed 3-bit scandoubler in the video output path of the Spectrum core.
- Sits between the (optionally monochrome-filtered) 15 kHz core video and the VGA pins.
- Ping-pong line buffers replay each captured input line twice at double rate.
- Adds configurable colour depth, programmable line capacity, four scanline attenuation levels, a generated VGA HSYNC window and a sticky line-overflow flag.

Parameters:
CDEPTH, 3, bits per colour channel.
HMAX, 1024, maximum input pixels stored per line; must be a power of two.
ADDRW, 10, line buffer address width; equals log2(HMAX).
HS_START, 16, output pixel index where the VGA HSYNC pulse begins.
HS_END, 72, output pixel index where the VGA HSYNC pulse ends (exclusive).

Ports:
clk  in  1  master clock (28 MHz)
rst  in  1  asynchronous reset, active high
clk14en  in  1  input pixel enable; strictly one clk in every two
enable_scandoubling  in  1  1 = VGA doubling, 0 = 15 kHz bypass
scan_level  in  2  0 none, 1 = 75 %, 2 = 50 %, 3 = 25 % brightness on replay lines
ri, gi, bi  in  CDEPTH each  input pixel colour
hsync_ext_n, vsync_ext_n, csync_ext_n  in  1 each  input syncs, active low
ro, go, bo  out  CDEPTH each  output colour
hsync, vsync  out  1 each  output syncs, active low
line_overflow  out  1  sticky: an input line exceeded HMAX pixels

Behaviour:
- Reset: ro/go/bo = 0, hsync = vsync = 1, line_overflow = 0, write/read counters = 0, buffer select = 0, replay flag = 0.
- Sampling: inputs are sampled only on clk14en. Input hsync falling edge = sampled hsync_ext_n goes 1→0 between consecutive enables.
- Write side: each clk14en writes {ri,gi,bi} to buffer[wsel] at wcnt, then wcnt increments.
  - On input hsync falling edge: linelen <= wcnt, wcnt <= 0, wsel toggles, read side restarts (rcnt = 0, replay = 0).
  - If wcnt reaches HMAX with no hsync edge, writes stop; wcnt holds at HMAX and line_overflow sets. It stays 1 until rst.
- Read side: reads buffer[~wsel] every clk cycle, so output runs at twice the input rate.
  - rcnt counts 0..linelen-1. At linelen-1: rcnt <= 0, replay <= 1.
  - At the end of the second pass, reads stop and output is black until the next input hsync edge.
  - linelen = 0 (first line after reset) gives black output and no HSYNC.
- HSYNC: hsync = 0 while HS_START <= rcnt < HS_END during either pass, otherwise 1.
  - If linelen <= HS_START, no pulse is produced.
- VSYNC: vsync_ext_n is sampled at each input hsync edge and driven onto vsync at the next output line start (rcnt = 0, replay = 0). Output VSYNC is therefore aligned to line boundaries.
- Scanlines: apply only when replay = 1. Each channel v becomes:
  - level 0: v
  - level 1: v - (v>>2)
  - level 2: v>>1
  - level 3: v>>2
  - Widths stay CDEPTH; results truncate and never underflow.
- Latency:
  - Output line N is input line N-1.
  - Pixel at rcnt = k appears on ro/go/bo two clk after rcnt = k is presented: one cycle for the RAM read, one for the scanline/output register.
  - hsync is delayed by the same two clk to stay aligned with the pixels.
- Bypass (enable_scandoubling = 0): ro/go/bo = ri/gi/bi registered on clk14en, hsync = csync_ext_n registered, vsync = 1. The buffers keep writing; the read side is ignored.
- Switching enable_scandoubling mid-line takes effect on the next clk; the line is not resynchronised.
- Simultaneous hsync edge and wcnt = HMAX: the edge wins. linelen = HMAX, wcnt is cleared, line_overflow still sets.
- rst asserted mid-line aborts immediately to reset values. Buffer contents are not cleared.

Test Plan:
- rst, then 2 input lines of 448 pixels at ramp colour (value = index mod 8), scan_level = 0 → from line 2 on, 896 output pixels per input line, two identical passes, hsync low exactly for rcnt 16..71 in each pass.
- Constant colour 7/7/7, scan_level = 1/2/3 → first pass outputs 7; replay pass outputs 6/3/1 respectively.
- Input line of 1100 pixels with HMAX = 1024 → line_overflow = 1 at pixel 1024 and stays 1; replayed length is 1024. Only rst clears the flag.
- vsync_ext_n low for 3 input lines → vsync low for exactly the 3 matching output lines (6 output passes), starting at rcnt = 0 of the first pass.
- enable_scandoubling = 0, ri = 5, csync_ext_n toggling → ro = 5 and hsync follows csync_ext_n one clk14en later; vsync = 1.
- rst asserted mid-replay → next clk gives ro/go/bo = 0, hsync = vsync = 1, line_overflow = 0. The first line after release is black with no HSYNC.
